jpeg_quant_pipe: RTL and testbench
==================================

JPEG_QUANT_PIPE -- requirements
Module: jpeg_quant_pipe

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning coefficients processed per beat (1, 2, 4 or 8).
REQ-002 SHALL have parameter DW, default 16, meaning signed input coefficient width per lane.
REQ-003 SHALL have parameter RW, default 16, meaning unsigned reciprocal width per lane.
REQ-004 SHALL have parameter SHIFT, default 17, meaning right-shift applied to the product.
REQ-005 SHALL have parameter OW, default 16, meaning signed output width per lane.
REQ-006 SHALL have parameter DEPTH, default 64, meaning coefficients per block; DEPTH/LANES is the number of beats per block (NBEAT).
REQ-007 SHALL have port clk_i, input, 1, the single clock; all state is rising-edge clocked.
REQ-008 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-010 SHALL have port in_ready_o, output, 1, input beat accepted when high with in_valid_i.
REQ-011 SHALL have port in_data_i, input, LANES*DW, coefficients; lane 0 in the MSBs.
REQ-012 SHALL have port blk_clr_i, input, 1, synchronous restart of the block index.
REQ-013 SHALL have port tab_we_i, input, 1, reciprocal table write strobe.
REQ-014 SHALL have port tab_addr_i, input, clog2(NBEAT), table beat address.
REQ-015 SHALL have port tab_data_i, input, LANES*RW, reciprocals; lane 0 in the MSBs.
REQ-016 SHALL have port out_valid_o, output, 1, output beat valid.
REQ-017 SHALL have port out_ready_i, input, 1, downstream accepts the beat.
REQ-018 SHALL have port out_data_o, output, LANES*OW, quantized coefficients; lane 0 in the MSBs.
REQ-019 SHALL have port out_last_o, output, 1, high on the final beat of a block.

Function
REQ-020 SHALL hold an NBEAT x LANES*RW reciprocal table; writes take effect at the clock edge; a same-cycle read of the address being written returns the old value.
REQ-021 SHALL keep a beat index 0..NBEAT-1 that selects the table word, increments on each input handshake and wraps from NBEAT-1 to 0.
REQ-022 SHALL clear the index to 0 on blk_clr_i; blk_clr_i with a simultaneous handshake uses index 0 for that beat and leaves the index at 1.
REQ-023 SHALL form a two-stage pipeline: stage 1 registers |x|*rec and the sign of x; stage 2 registers the rounded, signed, saturated result. Latency is 2 cycles from input handshake to out_valid_o when not stalled.
REQ-024 SHALL compute per lane q = (|x|*rec + 2^(SHIFT-1)) >> SHIFT, i.e. round half away from zero, and negate q when x < 0.
REQ-025 SHALL saturate q to [-(2^(OW-1)-1), 2^(OW-1)-1]; x = -2^(DW-1) SHALL use magnitude 2^(DW-1).
REQ-026 SHALL use one pipeline enable en = !out_valid_o || out_ready_i; in_ready_o = en; when en is low all stage registers hold.
REQ-027 SHALL carry valid and last flags through both stages; out_last_o is asserted only together with out_valid_o.
REQ-028 SHALL keep out_data_o and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-029 SHALL sustain one beat per cycle when out_ready_i is held high.

Reset
REQ-030 SHALL, on rst_i, asynchronously clear out_valid_o, out_last_o, out_data_o, both stage valid flags and the beat index; in_ready_o is 1 after reset.
REQ-031 SHALL NOT reset the reciprocal table; contents are undefined until written.
REQ-032 SHALL discard in-flight beats on reset mid-block; the next accepted beat is index 0.

Structure
REQ-033 SHALL place the default widths, SHIFT, DEPTH and the lane rounding/saturation function in shared package jpeg_quant_pkg.
REQ-034 SHALL instantiate one sub-module jpeg_quant_lane per lane (multiply, round, saturate); the top holds the table, index and handshake.

Verification
REQ-035 SHALL cover: LANES=2, rec=0x2000 both lanes, x={100,-100} -> out {13,-13} (12.5 rounds away from zero) 2 cycles later.
REQ-036 SHALL cover: x={-32768,32767}, rec=0xFFFF -> out {-32767,32767} (REQ-025 range).
REQ-037 SHALL cover: 32 back-to-back beats with out_ready_i=1 -> 32 outputs on consecutive cycles, out_last_o on beat 31 only, index wraps to 0.
REQ-038 SHALL cover: out_ready_i low 5 cycles mid-stream -> in_ready_o low, output held, no beat lost or duplicated.
REQ-039 SHALL cover: rst_i asserted at beat 10 and blk_clr_i at beat 5 -> out_valid_o drops immediately on reset; next beat uses table address 0.
REQ-040 SHALL cover: table write to address 3 in the same cycle as a beat reading address 3 -> that beat uses the old reciprocal; the next block uses the new one.

Source files
------------

// File: rtl/jpeg_quant_pkg.sv
// jpeg_quant_pkg
// Shared defaults and the per-lane round/saturate helper for the JPEG
// quantizer pipeline. No ports; imported by jpeg_quant_lane and
// jpeg_quant_pipe.
package jpeg_quant_pkg;

  localparam int LANES_DEF = 2;
  localparam int DW_DEF    = 16;
  localparam int RW_DEF    = 16;
  localparam int SHIFT_DEF = 17;
  localparam int OW_DEF    = 16;
  localparam int DEPTH_DEF = 64;

  // Rounds an unsigned magnitude product half away from zero, clamps it to
  // the symmetric range of an ow-bit signed value and applies the sign.
  // Working width is fixed at 64 bits so any lane geometry with
  // DW+RW < 64 fits; callers truncate the result to their output width.
  function automatic logic [63:0] round_sat(input logic [63:0] prod,
                                            input logic        neg,
                                            input int          shift,
                                            input int          ow);
    logic [63:0] q;
    logic [63:0] qmax;
    q    = (prod + (64'd1 << (shift - 1))) >> shift;
    qmax = (64'd1 << (ow - 1)) - 64'd1;
    if (q > qmax) q = qmax;
    return neg ? (~q + 64'd1) : q;
  endfunction

endpackage

// File: rtl/jpeg_quant_lane.sv
// jpeg_quant_lane
// One quantizer lane: stage 1 registers |x|*rec and the sign of x, stage 2
// registers the rounded, signed, saturated quotient. Both stages advance
// only when en_i is high.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   en_i          pipeline advance enable
//   x_i           signed coefficient (DW)
//   rec_i         unsigned reciprocal (RW)
//   q_o           signed quantized result (OW), registered
module jpeg_quant_lane
  import jpeg_quant_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OW    = OW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [DW-1:0] x_i,
  input  logic [RW-1:0] rec_i,
  output logic [OW-1:0] q_o
);

  logic [DW-1:0]    w_mag;
  logic [DW+RW-1:0] w_prod;
  logic [DW+RW-1:0] r_prod;
  logic             r_neg;
  logic [OW-1:0]    r_q;

  // Two's-complement negate treated as unsigned, so the most negative
  // input yields magnitude 2^(DW-1) rather than overflowing.
  assign w_mag  = x_i[DW-1] ? (~x_i + DW'(1)) : x_i;
  assign w_prod = (DW+RW)'(w_mag) * (DW+RW)'(rec_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prod <= '0;
      r_neg  <= 1'b0;
      r_q    <= '0;
    end else if (en_i) begin
      r_prod <= w_prod;
      r_neg  <= x_i[DW-1];
      r_q    <= OW'(round_sat(64'(r_prod), r_neg, SHIFT, OW));
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/jpeg_quant_pipe.sv
// jpeg_quant_pipe
// Multi-lane JPEG quantizer: multiplies each coefficient by a per-position
// reciprocal taken from a writable table, rounds, saturates and emits the
// result two cycles after the input handshake. A single enable stalls the
// whole pipeline when the output is held.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   in_valid_i/in_ready_o     input beat handshake
//   in_data_i                 LANES x DW coefficients, lane 0 in the MSBs
//   blk_clr_i                 restart block position at beat 0
//   tab_we_i/addr_i/data_i    reciprocal table write port (per beat)
//   out_valid_o/out_ready_i   output beat handshake
//   out_data_o                LANES x OW quantized values, lane 0 in MSBs
//   out_last_o                final beat of a block
module jpeg_quant_pipe
  import jpeg_quant_pkg::*;
#(
  parameter  int LANES = LANES_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int RW    = RW_DEF,
  parameter  int SHIFT = SHIFT_DEF,
  parameter  int OW    = OW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int NBEAT = DEPTH / LANES,
  localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [LANES*DW-1:0] in_data_i,
  input  logic                blk_clr_i,
  input  logic                tab_we_i,
  input  logic [IW-1:0]       tab_addr_i,
  input  logic [LANES*RW-1:0] tab_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [LANES*OW-1:0] out_data_o,
  output logic                out_last_o
);

  logic [LANES*RW-1:0] r_tab [NBEAT];
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_use;
  logic [IW-1:0]       w_idx_next;
  logic [LANES*RW-1:0] w_rec;
  logic                w_en;
  logic                w_hs;
  logic                w_last_in;
  logic                r_v1;
  logic                r_l1;
  logic                r_v2;
  logic                r_l2;

  assign w_en       = !r_v2 || out_ready_i;
  assign w_hs       = in_valid_i && w_en;
  assign in_ready_o = w_en;

  // A clear arriving with a beat applies to that beat, so the position
  // used this cycle is forced to 0 combinationally.
  assign w_idx_use  = blk_clr_i ? '0 : r_idx;
  assign w_last_in  = (w_idx_use == IW'(NBEAT - 1));
  assign w_idx_next = w_last_in ? '0 : (w_idx_use + IW'(1));

  // Asynchronous read of the registered table: a write in the same cycle
  // lands at the edge, so the current beat still sees the old word.
  assign w_rec = r_tab[w_idx_use];

  always_ff @(posedge clk_i) begin
    if (tab_we_i) r_tab[tab_addr_i] <= tab_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= w_idx_next;
    end else if (blk_clr_i) begin
      r_idx <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1 <= 1'b0;
      r_l1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l2 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= w_hs;
      r_l1 <= w_hs && w_last_in;
      r_v2 <= r_v1;
      r_l2 <= r_v1 && r_l1;
    end
  end

  assign out_valid_o = r_v2;
  assign out_last_o  = r_l2;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    jpeg_quant_lane #(
      .DW   (DW),
      .RW   (RW),
      .SHIFT(SHIFT),
      .OW   (OW)
    ) u_lane (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i (w_en),
      .x_i  (in_data_i[(LANES-1-l)*DW +: DW]),
      .rec_i(w_rec[(LANES-1-l)*RW +: RW]),
      .q_o  (out_data_o[(LANES-1-l)*OW +: OW])
    );
  end

endmodule

// File: tb/tb_jpeg_quant_pipe.sv
module tb_jpeg_quant_pipe;

  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int RW    = 16;
  // Shift of 16 makes rec=0x2000 map 100 -> 12.5 and lets 0xFFFF reach
  // the saturation limits.
  localparam int SH    = 16;
  localparam int OW    = 16;
  localparam int DEPTH = 64;
  localparam int NBEAT = DEPTH / LANES;
  localparam int IW    = $clog2(NBEAT);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                blk_clr;
  logic                tab_we;
  logic [IW-1:0]       tab_addr;
  logic [LANES*RW-1:0] tab_data;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*OW-1:0] out_data;
  logic                out_last;

  always #5 clk = ~clk;

  jpeg_quant_pipe #(
    .LANES(LANES), .DW(DW), .RW(RW), .SHIFT(SH), .OW(OW), .DEPTH(DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .blk_clr_i  (blk_clr),
    .tab_we_i   (tab_we),
    .tab_addr_i (tab_addr),
    .tab_data_i (tab_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_tab [NBEAT];
  int          m_idx;
  int          m_use;
  exp_t        m_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_out   = 0;
  int          n_last  = 0;
  int          first_out = -1;
  int          last_out  = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] qlane(input logic [15:0] x, input logic [15:0] r);
    longint mag, p, q;
    mag = longint'($signed(x));
    if (mag < 0) mag = -mag;
    p = mag * longint'({48'd0, r});
    q = (p + (longint'(1) << (SH - 1))) >>> SH;
    if (q > 32767) q = 32767;
    if ($signed(x) < 0) q = -q;
    return q[15:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] r);
    return {qlane(x[31:16], r[31:16]), qlane(x[15:0], r[15:0])};
  endfunction

  // Monitor / scoreboard: samples on the falling edge, ahead of the rising
  // edge where the handshakes it sees will take effect.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb_q.delete();
      m_idx = 0;
    end else begin
      if (!out_valid) check("last_without_valid", out_last, 0);
      if (out_valid && out_ready) begin
        check("sb_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          m_e = sb_q.pop_front();
          check("sb_data", out_data, m_e.data);
          check("sb_last", out_last, m_e.last);
          n_out++;
          if (out_last) n_last++;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end
      end
      if (in_valid && in_ready) begin
        m_use = blk_clr ? 0 : m_idx;
        m_e.data = model(in_data, m_tab[m_use]);
        m_e.last = (m_use == NBEAT - 1);
        sb_q.push_back(m_e);
        m_idx = (m_use == NBEAT - 1) ? 0 : m_use + 1;
      end else if (blk_clr) begin
        m_idx = 0;
      end
      if (tab_we) m_tab[tab_addr] = tab_data;
    end
  end

  // Called just after a rising edge; returns just after the edge at which
  // the beat was accepted.
  task automatic send_beat(input logic [15:0] x0, input logic [15:0] x1,
                           input logic clr, input logic we,
                           input logic [IW-1:0] wa, input logic [31:0] wd);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = {x0, x1};
    blk_clr  = clr;
    tab_we   = we;
    tab_addr = wa;
    tab_data = wd;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tab_we = 1'b0;
    end
    in_valid = 1'b0;
    blk_clr  = 1'b0;
    check("handshake_in_time", ok, 1);
  endtask

  task automatic write_tab(input logic [IW-1:0] a, input logic [31:0] d);
    tab_we   = 1'b1;
    tab_addr = a;
    tab_data = d;
    @(posedge clk);
    #1;
    tab_we = 1'b0;
  endtask

  // Single beat into an empty pipe with exact two-cycle latency check.
  task automatic lat_beat(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                          input logic [15:0] e0, input logic [15:0] e1);
    send_beat(x0, x1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, {e0, e1});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          n0, l0, c0;
  logic [31:0] held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    blk_clr   = 1'b0;
    tab_we    = 1'b0;
    tab_addr  = '0;
    tab_data  = '0;
    out_ready = 1'b1;
    m_idx     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int a = 0; a < NBEAT; a++) begin
      if (a == 0)      write_tab(IW'(a), 32'h2000_2000);
      else if (a == 1) write_tab(IW'(a), 32'hFFFF_FFFF);
      else             write_tab(IW'(a), $urandom);
    end

    // 100*0x2000 >> 16 = 12.5 -> 13, and symmetric for -100
    lat_beat("round", 16'd100, 16'hFF9C, 16'd13, 16'hFFF3);
    // most negative input and max positive both clamp to +/-32767
    lat_beat("sat", 16'h8000, 16'h7FFF, 16'h8001, 16'h7FFF);

    // full block back-to-back starting from a clear
    first_out = -1;
    n0 = n_out;
    l0 = n_last;
    c0 = cyc;
    for (int i = 0; i < NBEAT; i++)
      send_beat(16'($urandom), 16'($urandom), i == 0, 1'b0, '0, '0);
    check("b2b_in_cycles", cyc - c0, NBEAT);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_out_count", n_out - n0, NBEAT);
    check("b2b_out_span", last_out - first_out, NBEAT - 1);
    check("b2b_last_count", n_last - l0, 1);
    // index has wrapped: this beat must use table word 0
    send_beat(16'($urandom), 16'($urandom), 1'b0, 1'b0, '0, '0);
    drain();

    // output stall mid-stream
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send_beat(16'($urandom), 16'($urandom), 1'b0, 1'b0, '0, '0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = out_data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_hold", out_data, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_out_count", n_out - n0, 20);

    // clear at beat 5, reset at beat 10
    for (int i = 0; i < 10; i++)
      send_beat(16'($urandom), 16'($urandom), i == 5, 1'b0, '0, '0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // table word 0 (0x2000) must be used after reset
    lat_beat("post_rst", 16'd100, 16'hFF9C, 16'd13, 16'hFFF3);
    drain();

    // table write to address 3 while beat 3 reads it
    send_beat(16'h3000, 16'hC000, 1'b1, 1'b0, '0, '0);
    send_beat(16'h3000, 16'hC000, 1'b0, 1'b0, '0, '0);
    send_beat(16'h3000, 16'hC000, 1'b0, 1'b0, '0, '0);
    send_beat(16'h3000, 16'hC000, 1'b0, 1'b1, IW'(3), m_tab[3] ^ 32'h8000_8000);
    send_beat(16'h3000, 16'hC000, 1'b1, 1'b0, '0, '0);
    send_beat(16'h3000, 16'hC000, 1'b0, 1'b0, '0, '0);
    send_beat(16'h3000, 16'hC000, 1'b0, 1'b0, '0, '0);
    send_beat(16'h3000, 16'hC000, 1'b0, 1'b0, '0, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
